// File: rtl/pipe_stage_buf_if.sv
// Stage-to-stage bundle: upstream entry fields, downstream head fields and the handshake pair.
// The stage itself takes the slave view; whatever drives and consumes it takes the master view.
interface pipe_stage_buf_if #(
   parameter int unsigned DATA_W = 128,
   parameter int unsigned EXC_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instr_in;
   logic [31:0]       pc_in;
   logic [DATA_W-1:0] data_in;
   logic [EXC_W-1:0]  exc_in;
   logic              bd_in;
   logic              loc_exc;
   logic [EXC_W-1:0]  loc_exc_code;

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       instr_out;
   logic [31:0]       pc_out;
   logic [DATA_W-1:0] data_out;
   logic [EXC_W-1:0]  exc_out;
   logic              bd_out;

   modport slave (
      input  in_valid, instr_in, pc_in, data_in, exc_in, bd_in, loc_exc, loc_exc_code,
      output in_ready,
      output out_valid, instr_out, pc_out, data_out, exc_out, bd_out,
      input  out_ready
   );

   modport master (
      output in_valid, instr_in, pc_in, data_in, exc_in, bd_in, loc_exc, loc_exc_code,
      input  in_ready,
      input  out_valid, instr_out, pc_out, data_out, exc_out, bd_out,
      output out_ready
   );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// exception-code merging and req/clear flush that turns the head into a bubble.
module pipe_stage_buf #(
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned EXC_W      = 5,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter int unsigned SKID       = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 clear,
   pipe_stage_buf_if.slave      bus,
   output logic [1:0]           count
);

   typedef struct packed {
      logic [31:0]       instr;
      logic [31:0]       pc;
      logic [DATA_W-1:0] data;
      logic [EXC_W-1:0]  exc;
      logic              bd;
   } entry_t;

   entry_t           r_head, w_head_d, r_skid, w_skid_d, w_in;
   logic             r_head_v, w_head_v_d, r_skid_v, w_skid_v_d;
   logic             r_rdy, w_rdy_d;
   logic             w_in_ready, w_push, w_pop;
   logic [EXC_W-1:0] w_exc;

   // Earlier-stage exception always wins over the one raised locally.
   assign w_exc = (bus.exc_in != '0) ? bus.exc_in : (bus.loc_exc ? bus.loc_exc_code : '0);

   always_comb begin
      w_in       = '0;
      w_in.instr = bus.instr_in;
      w_in.pc    = bus.pc_in;
      w_in.data  = bus.data_in;
      w_in.exc   = w_exc;
      w_in.bd    = bus.bd_in;
   end

   assign w_in_ready = (SKID != 0) ? r_rdy : (!r_head_v || bus.out_ready);
   assign w_push     = bus.in_valid && w_in_ready;
   assign w_pop      = r_head_v && bus.out_ready;

   always_comb begin
      w_head_d   = r_head;
      w_head_v_d = r_head_v;
      w_skid_d   = r_skid;
      w_skid_v_d = r_skid_v;
      if (req || clear) begin
         w_head_d    = '0;
         w_head_d.pc = req ? HANDLER_PC : 32'h0;
         w_head_v_d  = 1'b0;
         w_skid_d    = '0;
         w_skid_v_d  = 1'b0;
      end else if (SKID == 0) begin
         if (w_push) begin
            w_head_d   = w_in;
            w_head_v_d = 1'b1;
         end else if (w_pop) begin
            // Bubble keeps the pc of the entry that just left.
            w_head_d    = '0;
            w_head_d.pc = r_head.pc;
            w_head_v_d  = 1'b0;
         end
      end else begin
         case ({r_head_v, r_skid_v})
            2'b00: begin
               if (w_push) begin
                  w_head_d   = w_in;
                  w_head_v_d = 1'b1;
               end
            end
            2'b10: begin
               if (w_push && !w_pop) begin
                  w_skid_d   = w_in;
                  w_skid_v_d = 1'b1;
               end else if (w_push && w_pop) begin
                  w_head_d = w_in;
               end else if (w_pop) begin
                  w_head_d    = '0;
                  w_head_d.pc = r_head.pc;
                  w_head_v_d  = 1'b0;
               end
            end
            2'b11: begin
               if (w_pop) begin
                  w_head_d   = r_skid;
                  w_skid_d   = '0;
                  w_skid_v_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
      w_rdy_d = !(w_head_v_d && w_skid_v_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head   <= '0;
         r_head_v <= 1'b0;
         r_skid   <= '0;
         r_skid_v <= 1'b0;
         r_rdy    <= 1'b1;
      end else begin
         r_head   <= w_head_d;
         r_head_v <= w_head_v_d;
         r_skid   <= w_skid_d;
         r_skid_v <= w_skid_v_d;
         r_rdy    <= w_rdy_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_head_v;
   assign bus.instr_out = r_head.instr;
   assign bus.pc_out    = r_head.pc;
   assign bus.data_out  = r_head.data;
   assign bus.exc_out   = r_head.exc;
   assign bus.bd_out    = r_head.bd;
   assign count         = {1'b0, r_head_v} + {1'b0, r_skid_v};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one skid instance (SKID=1) and one plain register (SKID=0)
// sharing clock, reset, req and clear.
module tb_pipe_stage_buf;
   localparam int unsigned DW = 128;
   localparam int unsigned EW = 5;

   logic       clk;
   logic       reset;
   logic       req;
   logic       clear;
   logic [1:0] count_s;
   logic [1:0] count_n;
   int         total;
   int         bad;

   pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW)) bs ();
   pipe_stage_buf_if #(.DATA_W(DW), .EXC_W(EW)) bn ();

   pipe_stage_buf #(.DATA_W(DW), .EXC_W(EW), .HANDLER_PC(32'h0000_4180), .SKID(1)) u_skid (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .clear (clear),
      .bus   (bs.slave),
      .count (count_s)
   );

   pipe_stage_buf #(.DATA_W(DW), .EXC_W(EW), .HANDLER_PC(32'h0000_4180), .SKID(0)) u_plain (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .clear (clear),
      .bus   (bn.slave),
      .count (count_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      req   = 1'b0;
      clear = 1'b0;
      bs.in_valid = 1'b1; bs.instr_in = 32'h11; bs.pc_in = 32'h3000; bs.data_in = '0;
      bs.exc_in = '0; bs.bd_in = 1'b0; bs.loc_exc = 1'b0; bs.loc_exc_code = '0;
      bs.out_ready = 1'b0;
      bn.in_valid = 1'b1; bn.instr_in = 32'h11; bn.pc_in = 32'h3000; bn.data_in = '0;
      bn.exc_in = '0; bn.bd_in = 1'b0; bn.loc_exc = 1'b0; bn.loc_exc_code = '0;
      bn.out_ready = 1'b0;

      // Reset held with in_valid asserted
      step();
      step();
      chk("rst_s_valid", 128'(bs.out_valid), 128'd0);
      chk("rst_s_count", 128'(count_s), 128'd0);
      chk("rst_s_pc", 128'(bs.pc_out), 128'd0);
      chk("rst_s_instr", 128'(bs.instr_out), 128'd0);
      chk("rst_s_inrdy", 128'(bs.in_ready), 128'd1);
      chk("rst_n_valid", 128'(bn.out_valid), 128'd0);
      chk("rst_n_count", 128'(count_n), 128'd0);

      reset = 1'b1;
      step();
      chk("push_s_valid", 128'(bs.out_valid), 128'd1);
      chk("push_s_pc", 128'(bs.pc_out), 128'h3000);
      chk("push_s_count", 128'(count_s), 128'd1);
      chk("push_n_valid", 128'(bn.out_valid), 128'd1);
      chk("push_n_pc", 128'(bn.pc_out), 128'h3000);
      bn.in_valid = 1'b0;
      #1;
      chk("n_stall_inrdy", 128'(bn.in_ready), 128'd0);

      // Skid fills to two entries, then drains in order
      bs.instr_in = 32'h22; bs.pc_in = 32'h3004;
      step();
      chk("fill_count", 128'(count_s), 128'd2);
      chk("fill_inrdy", 128'(bs.in_ready), 128'd0);
      chk("fill_head", 128'(bs.instr_out), 128'h11);
      bs.instr_in = 32'h77;
      step();
      chk("full_hold_count", 128'(count_s), 128'd2);
      chk("full_hold_head", 128'(bs.instr_out), 128'h11);
      bs.in_valid = 1'b0;
      bs.out_ready = 1'b1;
      step();
      chk("drain1_head", 128'(bs.instr_out), 128'h22);
      chk("drain1_count", 128'(count_s), 128'd1);
      chk("drain1_inrdy", 128'(bs.in_ready), 128'd1);
      step();
      chk("drain2_count", 128'(count_s), 128'd0);
      chk("drain2_valid", 128'(bs.out_valid), 128'd0);
      chk("drain2_instr", 128'(bs.instr_out), 128'd0);
      chk("drain2_pc", 128'(bs.pc_out), 128'h3004);

      // Exception merging
      bs.out_ready = 1'b0;
      bs.in_valid = 1'b1; bs.instr_in = 32'h33; bs.pc_in = 32'h3008;
      bs.exc_in = '0; bs.loc_exc = 1'b1; bs.loc_exc_code = 5'd12;
      step();
      chk("exc_local", 128'(bs.exc_out), 128'd12);
      chk("exc_local_count", 128'(count_s), 128'd1);
      bs.instr_in = 32'h34; bs.pc_in = 32'h300c; bs.exc_in = 5'd4; bs.bd_in = 1'b1;
      bs.data_in = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;
      bs.out_ready = 1'b1;
      step();
      chk("exc_earlier", 128'(bs.exc_out), 128'd4);
      chk("exc_bd", 128'(bs.bd_out), 128'd1);
      chk("exc_instr", 128'(bs.instr_out), 128'h34);
      chk("exc_data", bs.data_out, 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d);
      chk("pushpop_count", 128'(count_s), 128'd1);
      bs.instr_in = 32'h44; bs.exc_in = '0; bs.loc_exc = 1'b0; bs.bd_in = 1'b0;
      bs.data_in = '0; bs.out_ready = 1'b0;
      step();
      chk("refill_count", 128'(count_s), 128'd2);
      chk("refill_head", 128'(bs.instr_out), 128'h34);

      // req flush with a push pending
      req = 1'b1;
      bs.instr_in = 32'h55;
      step();
      req = 1'b0;
      chk("req_valid", 128'(bs.out_valid), 128'd0);
      chk("req_instr", 128'(bs.instr_out), 128'd0);
      chk("req_pc", 128'(bs.pc_out), 128'h4180);
      chk("req_count", 128'(count_s), 128'd0);
      chk("req_inrdy", 128'(bs.in_ready), 128'd1);
      chk("req_exc", 128'(bs.exc_out), 128'd0);
      chk("req_n_pc", 128'(bn.pc_out), 128'h4180);
      chk("req_n_valid", 128'(bn.out_valid), 128'd0);

      // req beats clear; clear alone gives pc 0
      bs.pc_in = 32'h3010;
      step();
      chk("pre_rc_valid", 128'(bs.out_valid), 128'd1);
      req = 1'b1; clear = 1'b1;
      step();
      req = 1'b0; clear = 1'b0;
      chk("reqclr_pc", 128'(bs.pc_out), 128'h4180);
      chk("reqclr_valid", 128'(bs.out_valid), 128'd0);
      bs.instr_in = 32'h66; bs.pc_in = 32'h3014;
      step();
      chk("pre_clr_instr", 128'(bs.instr_out), 128'h66);
      clear = 1'b1;
      step();
      clear = 1'b0;
      bs.in_valid = 1'b0;
      chk("clr_pc", 128'(bs.pc_out), 128'd0);
      chk("clr_valid", 128'(bs.out_valid), 128'd0);
      chk("clr_count", 128'(count_s), 128'd0);

      // SKID=0 streaming, one entry per cycle
      bn.out_ready = 1'b1;
      bn.in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bn.instr_in = 32'h100 + 32'(i);
         bn.pc_in = 32'h4000 + 32'(4 * i);
         step();
         chk("stream_valid", 128'(bn.out_valid), 128'd1);
         chk("stream_instr", 128'(bn.instr_out), 128'(32'h100 + 32'(i)));
      end
      bn.in_valid = 1'b0;
      bn.out_ready = 1'b0;
      #1;
      chk("comb_inrdy_lo", 128'(bn.in_ready), 128'd0);
      bn.out_ready = 1'b1;
      #1;
      chk("comb_inrdy_hi", 128'(bn.in_ready), 128'd1);
      step();
      chk("n_pop_valid", 128'(bn.out_valid), 128'd0);
      chk("n_pop_pc", 128'(bn.pc_out), 128'h400c);
      chk("n_pop_instr", 128'(bn.instr_out), 128'd0);

      // Asynchronous reset mid-transfer
      bs.in_valid = 1'b1; bs.instr_in = 32'h88; bs.out_ready = 1'b0;
      step();
      chk("pre_arst_valid", 128'(bs.out_valid), 128'd1);
      bs.in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_valid", 128'(bs.out_valid), 128'd0);
      chk("arst_count", 128'(count_s), 128'd0);
      chk("arst_instr", 128'(bs.instr_out), 128'd0);
      reset = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
